// File: rtl/cosim_msg_serializer.sv
// cosim_msg_serializer
// Converts one packed MSG_BITS-wide message into a byte-serial valid/ready
// stream. Byte 0 carries message bits [7:0]. The top byte is zero-padded
// above bit MSG_BITS-1, and out_last flags the final byte of each message.
//
// Optional feature macro: COSIM_SER_LEN_HEADER_EN
//   When defined, each message is preceded by one header byte equal to
//   MSG_BYTES[7:0], with out_last=0 on that byte.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-low reset
//   in_valid   message offered
//   in_ready   message accepted when in_valid && in_ready
//   in_data    message payload, sampled only on handshake
//   out_valid  byte offered
//   out_ready  byte consumed when out_valid && out_ready
//   out_data   current byte
//   out_last   final byte of a message, qualified by out_valid
//   busy       a message is held (capture+1 until its last byte handshakes)
module cosim_msg_serializer #(
  parameter int MSG_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MSG_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int MSG_BYTES = (MSG_BITS + 7) / 8;
  localparam int SHIFT_W   = MSG_BYTES * 8;
  localparam int IDX_W     = $clog2(MSG_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

`ifdef COSIM_SER_LEN_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, HDR = 2'd2} state_e;
  localparam state_e FIRST_ST = HDR;
  localparam logic [7:0] HDR_BYTE = 8'(MSG_BYTES);

  // The header byte carries the length in a single byte.
  if (MSG_BYTES > 255) begin : g_len_check
    $error("cosim_msg_serializer: MSG_BYTES must not exceed 255 with the length header");
  end
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;
  localparam state_e FIRST_ST = SEND;
`endif

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_hs_s;
  logic               in_hs_s;

  // Output decode: every output is a function of the state registers only,
  // so there is no combinational path from in_valid to out_*.
  always_comb begin
    out_valid = 1'b0;
    out_data  = shift_q[7:0];
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        out_valid = 1'b0;
        busy      = 1'b0;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (idx_q == LAST_IDX);
      end
`ifdef COSIM_SER_LEN_HEADER_EN
      HDR: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = HDR_BYTE;
      end
`endif
      default: begin
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // A new message may enter in the same cycle the last byte leaves, which
  // keeps a 1 byte/cycle rate across messages; reset masks acceptance.
  assign out_hs_s = out_valid && out_ready;
  assign in_ready = rst && ((state_q == IDLE) || (out_hs_s && out_last));
  assign in_hs_s  = in_valid && in_ready;

  // Next-state: capture, byte advance and message turnaround.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_hs_s) begin
          shift_d = SHIFT_W'(in_data);
          idx_d   = '0;
          state_d = FIRST_ST;
        end else begin
          state_d = IDLE;
        end
      end
`ifdef COSIM_SER_LEN_HEADER_EN
      HDR: begin
        if (out_hs_s) begin
          state_d = SEND;
        end else begin
          state_d = HDR;
        end
      end
`endif
      SEND: begin
        if (out_hs_s) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_hs_s) begin
              shift_d = SHIFT_W'(in_data);
              state_d = FIRST_ST;
            end else begin
              shift_d = shift_q >> 4'd8;
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q >> 4'd8;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; a partial message is
  // discarded and out_data returns to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_cosim_msg_serializer.sv
// Bench for cosim_msg_serializer: three instances (MSG_BITS = 32, 12, 1)
// share clock and reset. A byte-queue reference model predicts every
// output each cycle from the message rules (little-endian byte split,
// zero padding, optional length header).
module tb_cosim_msg_serializer;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid_s  [NDUT];
  logic        in_ready_s  [NDUT];
  logic [31:0] in_data_s   [NDUT];
  logic        out_valid_s [NDUT];
  logic        out_ready_s [NDUT];
  logic [7:0]  out_data_s  [NDUT];
  logic        out_last_s  [NDUT];
  logic        busy_s      [NDUT];

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // Expected byte stream per instance: {last, byte}.
  logic [8:0]  expq [NDUT][$];
  // Messages waiting to be offered per instance.
  logic [31:0] src  [NDUT][$];

  always #5 clk = ~clk;

  cosim_msg_serializer #(.MSG_BITS(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0]),
    .out_last(out_last_s[0]), .busy(busy_s[0])
  );

  cosim_msg_serializer #(.MSG_BITS(12)) u_dut12 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1][11:0]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1]),
    .out_last(out_last_s[1]), .busy(busy_s[1])
  );

  cosim_msg_serializer #(.MSG_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]), .in_data(in_data_s[2][0:0]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .out_data(out_data_s[2]),
    .out_last(out_last_s[2]), .busy(busy_s[2])
  );

  function automatic int bits_of(input int d);
    case (d)
      0:       bits_of = 32;
      1:       bits_of = 12;
      default: bits_of = 1;
    endcase
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // Split an accepted message into its expected byte sequence.
  task automatic push_msg(input int d, input logic [31:0] data);
    int          nb;
    logic [31:0] m;
    logic [31:0] b;
    nb = (bits_of(d) + 7) / 8;
    m  = (bits_of(d) == 32) ? data : (data & ((32'd1 << bits_of(d)) - 32'd1));
`ifdef COSIM_SER_LEN_HEADER_EN
    expq[d].push_back({1'b0, 8'(nb)});
`endif
    for (int i = 0; i < nb; i++) begin
      b = m >> (8 * i);
      expq[d].push_back({(i == nb - 1), b[7:0]});
    end
  endtask

  // One clock cycle: present inputs, check outputs mid-cycle, advance model.
  task automatic step();
    logic       ne;
    logic       exp_rdy;
    logic [8:0] f;
    for (int d = 0; d < NDUT; d++) begin
      in_valid_s[d] = (src[d].size() != 0);
      in_data_s[d]  = in_valid_s[d] ? src[d][0] : 32'h0;
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      ne = (expq[d].size() != 0);
      f  = ne ? expq[d][0] : 9'h0;
      chk("out_valid", d, {31'd0, out_valid_s[d]}, {31'd0, ne});
      chk("busy", d, {31'd0, busy_s[d]}, {31'd0, ne});
      if (ne) begin
        chk("out_data", d, {24'd0, out_data_s[d]}, {24'd0, f[7:0]});
        chk("out_last", d, {31'd0, out_last_s[d]}, {31'd0, f[8]});
      end
      exp_rdy = rst && (!ne || (out_ready_s[d] && f[8]));
      chk("in_ready", d, {31'd0, in_ready_s[d]}, {31'd0, exp_rdy});
      if (!rst) begin
        expq[d].delete();
      end else begin
        if (ne && out_ready_s[d]) begin
          void'(expq[d].pop_front());
        end
        if (in_valid_s[d] && exp_rdy) begin
          push_msg(d, src[d][0]);
          void'(src[d].pop_front());
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic pat [7];
    int   pending;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int d = 0; d < NDUT; d++) begin
      out_ready_s[d] = 1'b1;
      in_valid_s[d]  = 1'b0;
      in_data_s[d]   = 32'h0;
    end

    // Reset state.
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_out_data", d, {24'd0, out_data_s[d]}, 32'h0);
    end
    step();
    rst = 1'b1;

    // Basic messages on every width.
    src[0].push_back(32'hDDCCBBAA);
    src[1].push_back(32'h00000ABC);
    src[2].push_back(32'h00000001);
    repeat (7) step();

    // Backpressure on the 32-bit instance.
    src[0].push_back(32'hDDCCBBAA);
    step();
    for (int i = 0; i < 7; i++) begin
      out_ready_s[0] = pat[i];
      step();
    end
    out_ready_s[0] = 1'b1;
    repeat (3) step();

    // Back-to-back messages.
    src[0].push_back(32'h44332211);
    src[0].push_back(32'h88776655);
    repeat (11) step();

    // Reset in the middle of a message.
    src[0].push_back(32'hDDCCBBAA);
    repeat (3) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    src[0].push_back(32'h01020304);
    repeat (7) step();

    // Randomized traffic with backpressure and occasional resets.
    repeat (400) begin
      rst = ($urandom_range(0, 99) != 0);
      for (int d = 0; d < NDUT; d++) begin
        out_ready_s[d] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) == 0 && src[d].size() < 3) begin
          src[d].push_back($urandom);
        end
      end
      step();
    end

    // Drain everything with a bounded cycle budget.
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) out_ready_s[d] = 1'b1;
    for (int n = 0; n < 100; n++) begin
      pending = 0;
      for (int d = 0; d < NDUT; d++) pending += expq[d].size() + src[d].size();
      if (pending == 0) break;
      step();
    end
    pending = 0;
    for (int d = 0; d < NDUT; d++) pending += expq[d].size() + src[d].size();
    chk("drain", 0, pending, 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cosim_msg_serializer.md
# cosim_msg_serializer

Hardware-side transmitter that converts one packed message of `MSG_BITS` bits into a byte-serial valid/ready stream with an end-of-message flag. Byte order is the cosim endpoint byte order: byte 0 carries bits [7:0]. The top byte is zero-padded above bit `MSG_BITS-1`. The block sits between an ESI channel producer and a byte-wide host link that delivers whole messages to the cosim bridge.

## Interface

Parameters:
- `MSG_BITS`, default 32: message width in bits, must be ≥ 1. Derived `MSG_BYTES = (MSG_BITS+7)/8`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-low; clock `clk`.
- `in_valid`  in  1  message offered.
- `in_ready`  out  1  message accepted when `in_valid && in_ready`.
- `in_data`  in  `MSG_BITS`  message payload, sampled only on handshake.
- `out_valid`  out  1  byte offered.
- `out_ready`  in  1  byte consumed when `out_valid && out_ready`.
- `out_data`  out  8  current byte.
- `out_last`  out  1  marks the final byte of a message; qualified by `out_valid`.
- `busy`  out  1  a message is held; high from the capture cycle+1 until its last byte handshakes.

## Operation

- State machine states: IDLE, SEND, plus HDR when the header is compiled in.
- IDLE:
  - `in_ready`=1.
  - On input handshake, capture `in_data` zero-extended to `MSG_BYTES*8` into a shift register and clear the byte index.
  - Go to SEND, or to HDR if the header is compiled in.
- SEND:
  - `out_valid`=1 and `out_data`=shift[7:0].
  - `out_last` = (index == `MSG_BYTES-1`).
  - On output handshake: shift right by 8 and increment the index.
  - If the handshake is on the last byte, return to IDLE, or capture a new message (see back-to-back).
- Back-to-back: `in_ready` = IDLE || (`out_valid && out_ready && out_last`).
  - If a new message handshakes in the same cycle as the last byte, it is captured and SEND restarts at index 0 with no bubble.
- `MSG_BYTES`==1: the first and only byte has `out_last`=1.
- Index counter width is `$clog2(MSG_BYTES+1)`. The index never wraps past `MSG_BYTES-1`.
- Output stability: while `out_valid && !out_ready`, `out_data` and `out_last` hold their values. No byte is dropped or duplicated.
- `in_data` bits above `MSG_BITS` do not exist. Pad bits in the top byte are always 0.

## Timing

- Reset (`rst`=0 at `posedge clk`):
  - State becomes IDLE.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
  - `in_ready` is forced to 0 combinationally while `rst`=0.
- Reset mid-message: the partial message is discarded. After reset is released, the next accepted message starts at byte 0.
- Latency: message accepted on cycle N; first byte valid on cycle N+1.
- Throughput: with `out_ready` held at 1, a message takes exactly `MSG_BYTES` beats (`MSG_BYTES+1` with header). Sustained rate is 1 byte/cycle across messages.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_valid` to `out_*`.
- Simultaneous last-byte handshake and input handshake: the new message's byte 0 appears on cycle+1.

## Configuration

- `COSIM_SER_LEN_HEADER_EN` defined:
  - Each message is preceded by one header byte equal to `MSG_BYTES[7:0]`, sent in state HDR.
  - The header byte has `out_last`=0. HDR then transitions to SEND.
  - Elaboration fails (`$error`) if `MSG_BYTES > 255`.
- Macro not defined: no HDR state; only payload bytes are emitted.

## Test plan

- `MSG_BITS`=32, `in_data`=0xDDCCBBAA, `out_ready`=1:
  - Bytes AA, BB, CC, DD on cycles N+1..N+4.
  - `out_last` only with DD; `busy` falls on N+5.
- `MSG_BITS`=12, `in_data`=0xABC:
  - Bytes BC then 0A, upper nibble 0, `out_last` on 0A.
  - `MSG_BITS`=1, `in_data`=1 → single byte 01 with `out_last`=1.
- Backpressure: `out_ready` pattern 1,0,0,1,0,1,1 on 0xDDCCBBAA.
  - Each byte is held stable while not ready; exactly AA, BB, CC, DD emitted.
  - `in_ready`=0 until DD handshakes.
- Back-to-back: `in_valid` held with 0x44332211 then 0x88776655, `out_ready`=1.
  - Eight contiguous beats 11..88.
  - `in_ready` high only on the 0x44 beat, then on the 0x88 beat.
- Reset mid-message: `rst`=0 after two bytes of 0xDDCCBBAA.
  - Next cycle `out_valid`=0 and `busy`=0; `in_ready`=0 during reset.
  - A new message 0x01020304 emits 04, 03, 02, 01.
- With `COSIM_SER_LEN_HEADER_EN`, `MSG_BITS`=32, 0xDDCCBBAA:
  - 04, AA, BB, CC, DD.
  - `out_last` only on DD; 5 beats total.
